// File: rtl/monopix_rx_pkg.sv
// monopix_rx_pkg
//   Shared types for the hit receive path: the deserialized hit layout
//   (t_data), the packed 32-bit output word (t_hit_word), the flavour IDs
//   and the 6-bit Gray-to-binary decoder used for the LE/TE timestamps.
package monopix_rx_pkg;

    localparam logic [1:0] FLAVOR_PMOS_NOSF = 2'd0;
    localparam logic [1:0] FLAVOR_PMOS      = 2'd1;
    localparam logic [1:0] FLAVOR_COMP      = 2'd2;
    localparam logic [1:0] FLAVOR_HV        = 2'd3;

    localparam int DATA_W = 27;
    localparam int HIT_W  = 32;

    // Deserializer output, MSB first: {col, te, le, row}
    typedef struct packed {
        logic [5:0] col;
        logic [5:0] te;
        logic [5:0] le;
        logic [8:0] row;
    } t_data;

    // Output word; te_f carries either te_bin or ToT depending on build
    typedef struct packed {
        logic [1:0] flavor;
        logic [5:0] col;
        logic [8:0] row;
        logic [5:0] le;
        logic [5:0] te_f;
        logic [2:0] pad;
    } t_hit_word;

    function automatic logic [5:0] gray2bin6(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/hit_rx_fifo_mem.sv
// hit_rx_fifo_mem
//   Show-ahead FIFO: DEPTH x W register array with wrapping pointers.
//   Ports:
//     clk, rst          clock, async active-high reset
//     wr_en, wr_data    write request; accepted unless full without a pop
//     rd_en             pop request; ignored while empty
//     rd_data           head entry (always driven from the array)
//     count/full/empty  occupancy status
module hit_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_wr, do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // When full, a concurrent pop frees the head slot, which is exactly the
    // slot wr_ptr points at, so the write lands there as the new tail.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/hit_rx_fifo.sv
// hit_rx_fifo
//   Receives deserialized hits, Gray-decodes LE/TE, packs a 32-bit word
//   tagged with FLAVOR and buffers it in a show-ahead FIFO. Input has no
//   backpressure, so words arriving while full are counted as lost.
//   Build option: HIT_RX_TOT_EN puts ToT=(te-le) mod 64 in dout[8:3]
//   instead of the decoded TE.
//   Ports:
//     clk_out, reset              clock, async active-high reset
//     data_in, data_in_strobe     hit {col,te,le,row} with 1-cycle strobe
//     dout, dout_valid, dout_ready  head word, valid/ready handshake
//     fifo_count                  words stored
//     overflow, lost_cnt          sticky drop flag, saturating drop count
//     clear_lost                  clears overflow/lost_cnt (a drop wins)
module hit_rx_fifo
    import monopix_rx_pkg::*;
#(
    parameter logic [1:0] FLAVOR = 2'd0,
    parameter int         DEPTH  = 16,
    parameter int         LOST_W = 8
) (
    input  logic                     clk_out,
    input  logic                     reset,
    input  logic [26:0]              data_in,
    input  logic                     data_in_strobe,
    output logic [31:0]              dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [LOST_W-1:0]        lost_cnt,
    input  logic                     clear_lost
);

    t_data       din;
    t_hit_word   s1_word_q, s1_word_d;
    logic        s1_valid_q, s1_valid_d;
    logic        overflow_q, overflow_d;
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [5:0]  le_bin, te_bin;
    logic        fifo_full, fifo_empty, pop, drop;

    assign din = t_data'(data_in);

    // Stage 1: decode and pack
    always_comb begin
        le_bin     = gray2bin6(din.le);
        te_bin     = gray2bin6(din.te);
        s1_valid_d = data_in_strobe;
        s1_word_d  = s1_word_q;
        if (data_in_strobe) begin
            s1_word_d.flavor = FLAVOR;
            s1_word_d.col    = din.col;
            s1_word_d.row    = din.row;
            s1_word_d.le     = le_bin;
`ifdef HIT_RX_TOT_EN
            s1_word_d.te_f   = te_bin - le_bin;  // wraps mod 64
`else
            s1_word_d.te_f   = te_bin;
`endif
            s1_word_d.pad    = 3'b000;
        end
    end

    // Stage 2: FIFO write; drop only when full with no pop this cycle
    assign pop  = dout_valid && dout_ready;
    assign drop = s1_valid_q && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        lost_cnt_d = lost_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_lost) begin
                lost_cnt_d = LOST_W'(1);
            end else if (lost_cnt_q != '1) begin
                lost_cnt_d = lost_cnt_q + 1'b1;
            end
        end else if (clear_lost) begin
            overflow_d = 1'b0;
            lost_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            s1_word_q  <= '0;
            s1_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            lost_cnt_q <= '0;
        end else begin
            s1_word_q  <= s1_word_d;
            s1_valid_q <= s1_valid_d;
            overflow_q <= overflow_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    hit_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (HIT_W)
    ) u_mem (
        .clk     (clk_out),
        .rst     (reset),
        .wr_en   (s1_valid_q),
        .wr_data (s1_word_q),
        .rd_en   (pop),
        .rd_data (dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign overflow   = overflow_q;
    assign lost_cnt   = lost_cnt_q;

endmodule

// File: tb/tb_hit_rx_fifo.sv
module tb_hit_rx_fifo;

    logic        clk_out = 1'b0;
    logic        reset;
    logic [26:0] data_in;
    logic        data_in_strobe;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  lost_cnt;
    logic        clear_lost;

    int n_tests = 0;
    int n_fail  = 0;

    hit_rx_fifo #(.FLAVOR(2'd0), .DEPTH(16), .LOST_W(8)) dut (
        .clk_out        (clk_out),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_strobe (data_in_strobe),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .lost_cnt       (lost_cnt),
        .clear_lost     (clear_lost)
    );

    always #5 clk_out = ~clk_out;

    localparam logic [26:0] HIT_A  = {6'd7, 6'b001111, 6'b000111, 9'd100};
    localparam logic [26:0] HIT_W  = {6'd0, 6'b000010, 6'b100010, 9'd0};
    localparam logic [26:0] HIT_X  = {6'd63, 6'b000000, 6'b000000, 9'd511};
    localparam logic [31:0] EXP_X  = 32'h3FFF8000;
`ifdef HIT_RX_TOT_EN
    localparam logic [31:0] EXP_A  = 32'h07320A28;
    localparam logic [31:0] EXP_W  = 32'h00007838;
    localparam logic [5:0]  EXP_WF = 6'd7;
`else
    localparam logic [31:0] EXP_A  = 32'h07320A50;
    localparam logic [31:0] EXP_W  = 32'h00007818;
    localparam logic [5:0]  EXP_WF = 6'd3;
`endif

    // Fill pattern: col=i, row=3i+1, LE/TE Gray 0 (so ToT/TE field is 0)
    function automatic logic [26:0] fill_in(input int i);
        return {6'(i), 6'b0, 6'b0, 9'(3 * i + 1)};
    endfunction
    function automatic logic [31:0] fill_exp(input int i);
        return {2'b00, 6'(i), 9'(3 * i + 1), 15'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one strobe starting at a falling edge; returns at the next one
    task automatic strobe(input logic [26:0] d);
        data_in        = d;
        data_in_strobe = 1'b1;
        @(negedge clk_out);
        data_in_strobe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; data_in = '0; data_in_strobe = 1'b0;
        dout_ready = 1'b0; clear_lost = 1'b0;
        @(negedge clk_out);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);
        chk("rst_lost",  32'(lost_cnt),   32'd0);
        chk("rst_dout",  dout,            32'd0);
        reset = 1'b0;
        @(negedge clk_out);

        // Single hit: latency 2 edges
        strobe(HIT_A);
        chk("lat_s1_valid", 32'(dout_valid), 32'd0);
        @(negedge clk_out);
        chk("lat_valid", 32'(dout_valid), 32'd1);
        chk("hit_a",     dout,            EXP_A);
        dout_ready = 1'b1; @(negedge clk_out); dout_ready = 1'b0;
        chk("pop_a_count", 32'(fifo_count), 32'd0);

        // Empty pop is ignored
        dout_ready = 1'b1; @(negedge clk_out); dout_ready = 1'b0;
        chk("empty_pop_count", 32'(fifo_count), 32'd0);
        chk("empty_pop_valid", 32'(dout_valid), 32'd0);

        // ToT wrap
        strobe(HIT_W);
        @(negedge clk_out);
        chk("wrap_field", 32'(dout[8:3]), 32'(EXP_WF));
        chk("wrap_word",  dout,           EXP_W);
        dout_ready = 1'b1; @(negedge clk_out); dout_ready = 1'b0;

        // Fill past full: 20 back-to-back strobes
        for (int i = 0; i < 20; i++) begin
            data_in = fill_in(i); data_in_strobe = 1'b1;
            @(negedge clk_out);
        end
        data_in_strobe = 1'b0;
        @(negedge clk_out); @(negedge clk_out);
        chk("fill_count", 32'(fifo_count), 32'd16);
        chk("fill_ovf",   32'(overflow),   32'd1);
        chk("fill_lost",  32'(lost_cnt),   32'd4);
        chk("fill_head",  dout,            fill_exp(0));

        // Full with simultaneous write and pop
        strobe(HIT_X);
        dout_ready = 1'b1;
        @(negedge clk_out);
        dout_ready = 1'b0;
        chk("simul_count", 32'(fifo_count), 32'd16);
        chk("simul_lost",  32'(lost_cnt),   32'd4);
        dout_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("order_%0d", k), dout, fill_exp(k));
            @(negedge clk_out);
        end
        chk("order_last", dout, EXP_X);
        @(negedge clk_out);
        dout_ready = 1'b0;
        chk("drain_count", 32'(fifo_count), 32'd0);
        chk("drain_valid", 32'(dout_valid), 32'd0);

        // clear_lost coinciding with a drop
        for (int i = 0; i < 17; i++) begin
            data_in = fill_in(i); data_in_strobe = 1'b1;
            @(negedge clk_out);
        end
        data_in_strobe = 1'b0;
        @(negedge clk_out); @(negedge clk_out);
        chk("refill_lost", 32'(lost_cnt), 32'd5);
        strobe(HIT_X);
        clear_lost = 1'b1;
        @(negedge clk_out);
        clear_lost = 1'b0;
        chk("clr_drop_lost", 32'(lost_cnt), 32'd1);
        chk("clr_drop_ovf",  32'(overflow), 32'd1);
        clear_lost = 1'b1;
        @(negedge clk_out);
        clear_lost = 1'b0;
        chk("clr_lost", 32'(lost_cnt),   32'd0);
        chk("clr_ovf",  32'(overflow),   32'd0);
        chk("clr_count", 32'(fifo_count), 32'd16);

        // Async reset with 5 words stored
        reset = 1'b1; #1;
        chk("rst2_count", 32'(fifo_count), 32'd0);
        @(negedge clk_out);
        reset = 1'b0;
        @(negedge clk_out);
        for (int i = 0; i < 5; i++) begin
            data_in = fill_in(i); data_in_strobe = 1'b1;
            @(negedge clk_out);
        end
        data_in_strobe = 1'b0;
        @(negedge clk_out); @(negedge clk_out);
        chk("five_count", 32'(fifo_count), 32'd5);
        @(posedge clk_out); #3;
        reset = 1'b1; #1;
        chk("async_valid", 32'(dout_valid), 32'd0);
        chk("async_count", 32'(fifo_count), 32'd0);
        chk("async_dout",  dout,            32'd0);
        @(negedge clk_out);
        reset = 1'b0;
        @(negedge clk_out);
        strobe(HIT_A);
        chk("post_rst_s1", 32'(dout_valid), 32'd0);
        @(negedge clk_out);
        chk("post_rst_valid", 32'(dout_valid), 32'd1);
        chk("post_rst_word",  dout,            EXP_A);
        chk("post_rst_count", 32'(fifo_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
